// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use and load-branch hazard detection
// Optional bubble/flush performance counters are enabled by defining ID_EX_PERF_CNT_EN.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module id_ex_pipe_reg #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [XLEN-1:0]           ID_pc,
    input  logic [XLEN-1:0]           ID_rs1_data,
    input  logic [XLEN-1:0]           ID_rs2_data,
    input  logic [XLEN-1:0]           ID_imm,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rd,
    input  logic                      ID_uses_rs1,
    input  logic                      ID_uses_rs2,
    input  logic                      ID_is_branch,
    input  logic                      ID_valid,
    input  logic                      ID_reg_wr_en,
    input  logic                      ID_mem_rd_en,
    input  logic                      ID_mem_wr_en,
    input  logic                      ID_mem_to_reg,
    input  logic                      ID_alu_src,
    input  logic [3:0]                ID_alu_op,
    input  logic                      EX_MEM_mem_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
    input  logic                      ex_hold,
    input  logic                      flush,
    output logic                      hazard_stall,
    output logic [XLEN-1:0]           ID_EX_pc,
    output logic [XLEN-1:0]           ID_EX_rs1_data,
    output logic [XLEN-1:0]           ID_EX_rs2_data,
    output logic [XLEN-1:0]           ID_EX_imm,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_rs1,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_rs2,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    output logic                      ID_EX_valid,
    output logic                      ID_EX_reg_wr_en,
    output logic                      ID_EX_mem_rd_en,
    output logic                      ID_EX_mem_wr_en,
    output logic                      ID_EX_mem_to_reg,
    output logic                      ID_EX_alu_src,
    output logic [3:0]                ID_EX_alu_op,
    output logic [31:0]               bubble_cnt,
    output logic [31:0]               flush_cnt
);

    localparam int W = 4*XLEN + 3*REG_ADDR_WIDTH + 10;

    logic [W-1:0] w_id;
    logic [W-1:0] r_id_ex;
    logic         w_lu;
    logic         w_lb;

    // A bubble is simply the all-zero image of this flat register
    assign w_id = {ID_pc, ID_rs1_data, ID_rs2_data, ID_imm,
                   ID_rs1, ID_rs2, ID_rd,
                   ID_valid, ID_reg_wr_en, ID_mem_rd_en, ID_mem_wr_en,
                   ID_mem_to_reg, ID_alu_src, ID_alu_op};

    assign {ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
            ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
            ID_EX_valid, ID_EX_reg_wr_en, ID_EX_mem_rd_en, ID_EX_mem_wr_en,
            ID_EX_mem_to_reg, ID_EX_alu_src, ID_EX_alu_op} = r_id_ex;

    assign w_lu = ID_valid & ID_EX_valid & ID_EX_mem_rd_en & (ID_EX_rd != '0) &
                  ((ID_uses_rs1 & (ID_rs1 == ID_EX_rd)) |
                   (ID_uses_rs2 & (ID_rs2 == ID_EX_rd)));

    // Branches compare in ID, so load data still sitting in EX/MEM cannot reach them
    assign w_lb = ID_valid & ID_is_branch & EX_MEM_mem_rd_en & (EX_MEM_rd != '0) &
                  ((ID_uses_rs1 & (ID_rs1 == EX_MEM_rd)) |
                   (ID_uses_rs2 & (ID_rs2 == EX_MEM_rd)));

    assign hazard_stall = (w_lu | w_lb) & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id_ex <= '0;
        end else if (flush) begin
            r_id_ex <= '0;
        end else if (!ex_hold) begin
            r_id_ex <= hazard_stall ? '0 : w_id;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (!flush && !ex_hold && hazard_stall && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`else
    assign bubble_cnt = 32'd0;
    assign flush_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - self-checking bench for id_ex_pipe_reg (honours ID_EX_PERF_CNT_EN)
`timescale 1ns/1ps

module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        valid, wr, mrd, mwr, m2r, asrc;
        logic [3:0]  op;
    } ix_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ID_pc, ID_rs1_data, ID_rs2_data, ID_imm;
    logic [4:0]  ID_rs1, ID_rs2, ID_rd;
    logic        ID_uses_rs1, ID_uses_rs2, ID_is_branch, ID_valid;
    logic        ID_reg_wr_en, ID_mem_rd_en, ID_mem_wr_en, ID_mem_to_reg, ID_alu_src;
    logic [3:0]  ID_alu_op;
    logic        EX_MEM_mem_rd_en;
    logic [4:0]  EX_MEM_rd;
    logic        ex_hold, flush;
    logic        hazard_stall;
    logic [31:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic        ID_EX_valid, ID_EX_reg_wr_en, ID_EX_mem_rd_en, ID_EX_mem_wr_en;
    logic        ID_EX_mem_to_reg, ID_EX_alu_src;
    logic [3:0]  ID_EX_alu_op;
    logic [31:0] bubble_cnt, flush_cnt;

    int n_total = 0;
    int n_pass  = 0;
    bit run_cmp = 1'b0;

    ix_t         m = '0;
    longint      m_bub = 0;
    longint      m_fl  = 0;
    logic        pipe_mrd = 1'b0;
    logic [4:0]  pipe_rd  = '0;

    id_ex_pipe_reg #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_pc(ID_pc), .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .ID_is_branch(ID_is_branch),
        .ID_valid(ID_valid), .ID_reg_wr_en(ID_reg_wr_en), .ID_mem_rd_en(ID_mem_rd_en),
        .ID_mem_wr_en(ID_mem_wr_en), .ID_mem_to_reg(ID_mem_to_reg), .ID_alu_src(ID_alu_src),
        .ID_alu_op(ID_alu_op), .EX_MEM_mem_rd_en(EX_MEM_mem_rd_en), .EX_MEM_rd(EX_MEM_rd),
        .ex_hold(ex_hold), .flush(flush), .hazard_stall(hazard_stall),
        .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
        .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_valid(ID_EX_valid), .ID_EX_reg_wr_en(ID_EX_reg_wr_en),
        .ID_EX_mem_rd_en(ID_EX_mem_rd_en), .ID_EX_mem_wr_en(ID_EX_mem_wr_en),
        .ID_EX_mem_to_reg(ID_EX_mem_to_reg), .ID_EX_alu_src(ID_EX_alu_src),
        .ID_EX_alu_op(ID_EX_alu_op), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_stall();
        bit hz = 1'b0;
        for (int s = 0; s < 2; s++) begin
            logic       u = (s == 0) ? ID_uses_rs1 : ID_uses_rs2;
            logic [4:0] r = (s == 0) ? ID_rs1 : ID_rs2;
            if (ID_valid && u && m.valid && m.mrd && m.rd != 0 && r == m.rd) hz = 1'b1;
            if (ID_valid && u && ID_is_branch && EX_MEM_mem_rd_en && EX_MEM_rd != 0 && r == EX_MEM_rd)
                hz = 1'b1;
        end
        return hz && !flush;
    endfunction

    function automatic longint exp_bub();
`ifdef ID_EX_PERF_CNT_EN
        return m_bub;
`else
        return 0;
`endif
    endfunction

    function automatic longint exp_fl();
`ifdef ID_EX_PERF_CNT_EN
        return m_fl;
`else
        return 0;
`endif
    endfunction

    // Model of the register plus a simple EX/MEM stage that feeds the load-branch check
    always @(posedge clk) begin
        bit st;
        st = model_stall();
        if (!rst_n) begin
            pipe_mrd = 1'b0; pipe_rd = '0;
        end else if (!ex_hold) begin
            pipe_mrd = m.valid & m.mrd; pipe_rd = m.rd;
        end
        if (!rst_n) begin
            m = '0; m_bub = 0; m_fl = 0;
        end else if (flush) begin
            m = '0;
            if (m_fl < 64'hFFFF_FFFF) m_fl++;
        end else if (ex_hold) begin
            m = m;
        end else if (st) begin
            m = '0;
            if (m_bub < 64'hFFFF_FFFF) m_bub++;
        end else begin
            m = '{pc: ID_pc, rs1d: ID_rs1_data, rs2d: ID_rs2_data, imm: ID_imm,
                  rs1: ID_rs1, rs2: ID_rs2, rd: ID_rd, valid: ID_valid, wr: ID_reg_wr_en,
                  mrd: ID_mem_rd_en, mwr: ID_mem_wr_en, m2r: ID_mem_to_reg,
                  asrc: ID_alu_src, op: ID_alu_op};
        end
    end

    always @(negedge clk) begin
        ix_t a;
        if (run_cmp) begin
            a = {ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
                 ID_EX_valid, ID_EX_reg_wr_en, ID_EX_mem_rd_en, ID_EX_mem_wr_en,
                 ID_EX_mem_to_reg, ID_EX_alu_src, ID_EX_alu_op};
            chk("model_id_ex", 160'(a), 160'(m));
            chk("model_stall", 160'(hazard_stall), 160'(model_stall()));
            chk("model_bubble_cnt", 160'(bubble_cnt), 160'(exp_bub()));
            chk("model_flush_cnt", 160'(flush_cnt), 160'(exp_fl()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        EX_MEM_mem_rd_en = pipe_mrd;
        EX_MEM_rd        = pipe_rd;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic br, input logic wr, input logic ld);
        ID_pc = pc; ID_rs1_data = pc ^ 32'hA5A5_0000; ID_rs2_data = ~pc; ID_imm = pc + 32'd4;
        ID_rs1 = r1; ID_rs2 = r2; ID_rd = rd;
        ID_uses_rs1 = u1; ID_uses_rs2 = u2; ID_is_branch = br; ID_valid = 1'b1;
        ID_reg_wr_en = wr; ID_mem_rd_en = ld; ID_mem_wr_en = 1'b0; ID_mem_to_reg = ld;
        ID_alu_src = ~u2; ID_alu_op = pc[5:2];
    endtask

    initial begin
        rst_n = 1'b0; ex_hold = 1'b0; flush = 1'b0;
        EX_MEM_mem_rd_en = 1'b0; EX_MEM_rd = '0;
        set_id(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ID_valid = 1'b0;
        tick(); tick();
        run_cmp = 1'b1;
        chk("rst_valid", 160'(ID_EX_valid), 160'(0));
        chk("rst_pc", 160'(ID_EX_pc), 160'(0));
        chk("rst_stall", 160'(hazard_stall), 160'(0));
        chk("rst_bubble_cnt", 160'(bubble_cnt), 160'(0));
        chk("rst_flush_cnt", 160'(flush_cnt), 160'(0));

        // Reset then capture
        rst_n = 1'b1;
        set_id(32'h100, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("cap_pc", 160'(ID_EX_pc), 160'(32'h100));
        chk("cap_rd", 160'(ID_EX_rd), 160'(5));
        chk("cap_valid", 160'(ID_EX_valid), 160'(1));

        // Load-use: lw x5 then add x6,x5,x7
        set_id(32'h104, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(32'h108, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 chk("lu_stall", 160'(hazard_stall), 160'(1));
        tick();
        chk("lu_bubble_valid", 160'(ID_EX_valid), 160'(0));
        chk("lu_bubble_rd", 160'(ID_EX_rd), 160'(0));
        chk("lu_bubble_wr", 160'(ID_EX_reg_wr_en), 160'(0));
        chk("lu_stall_off", 160'(hazard_stall), 160'(0));
`ifdef ID_EX_PERF_CNT_EN
        chk("lu_bubble_cnt", 160'(bubble_cnt), 160'(1));
`else
        chk("lu_bubble_cnt_off", 160'(bubble_cnt), 160'(0));
        chk("lu_flush_cnt_off", 160'(flush_cnt), 160'(0));
`endif
        tick();
        chk("lu_add_rd", 160'(ID_EX_rd), 160'(6));
        chk("lu_add_pc", 160'(ID_EX_pc), 160'(32'h108));

        // Load-branch: lw x5 then beq x5,x0 stalls two cycles
        set_id(32'h10C, 5'd3, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(32'h110, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 chk("lb_stall1", 160'(hazard_stall), 160'(1));
        tick();
        #1 chk("lb_stall2", 160'(hazard_stall), 160'(1));
        chk("lb_bubble1", 160'(ID_EX_valid), 160'(0));
        tick();
        #1 chk("lb_stall_off", 160'(hazard_stall), 160'(0));
        chk("lb_bubble2", 160'(ID_EX_valid), 160'(0));
        tick();
        chk("lb_br_valid", 160'(ID_EX_valid), 160'(1));
        chk("lb_br_pc", 160'(ID_EX_pc), 160'(32'h110));
`ifdef ID_EX_PERF_CNT_EN
        chk("lb_bubble_cnt", 160'(bubble_cnt), 160'(3));
`endif

        // Zero register: lw x0 then add x1,x0,x0
        set_id(32'h114, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(32'h118, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 chk("x0_stall", 160'(hazard_stall), 160'(0));
        tick();
        chk("x0_rd", 160'(ID_EX_rd), 160'(1));
        chk("x0_valid", 160'(ID_EX_valid), 160'(1));

        // Invalid ID slot never stalls and is captured as-is
        set_id(32'h11C, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(32'h120, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        ID_valid = 1'b0;
        #1 chk("inv_stall", 160'(hazard_stall), 160'(0));
        tick();
        chk("inv_valid", 160'(ID_EX_valid), 160'(0));
        chk("inv_rd", 160'(ID_EX_rd), 160'(9));

        // Hold for 3 cycles, then flush with hold
        set_id(32'h200, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        ex_hold = 1'b1;
        set_id(32'h204, 5'd3, 5'd4, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_pc", 160'(ID_EX_pc), 160'(32'h200));
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; ex_hold = 1'b0;
        chk("flush_valid", 160'(ID_EX_valid), 160'(0));
        chk("flush_pc", 160'(ID_EX_pc), 160'(0));
`ifdef ID_EX_PERF_CNT_EN
        chk("flush_cnt1", 160'(flush_cnt), 160'(1));
`else
        chk("flush_cnt_off", 160'(flush_cnt), 160'(0));
`endif

        // Stall stays asserted under hold, register holds the load
        set_id(32'h300, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(32'h304, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        ex_hold = 1'b1;
        #1 chk("hs_stall", 160'(hazard_stall), 160'(1));
        tick();
        #1 chk("hs_stall_held", 160'(hazard_stall), 160'(1));
        chk("hs_pc", 160'(ID_EX_pc), 160'(32'h300));
        ex_hold = 1'b0;
        tick();
        chk("hs_bubble", 160'(ID_EX_valid), 160'(0));

        // Flush masks a pending stall
        set_id(32'h308, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(32'h30C, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        #1 chk("fs_stall", 160'(hazard_stall), 160'(0));
        tick();
        flush = 1'b0;
        chk("fs_valid", 160'(ID_EX_valid), 160'(0));
`ifdef ID_EX_PERF_CNT_EN
        chk("fs_flush_cnt", 160'(flush_cnt), 160'(2));
        chk("fs_bubble_cnt", 160'(bubble_cnt), 160'(4));
`endif
        tick();
        chk("fs_capture", 160'(ID_EX_pc), 160'(32'h30C));

        // Reset asserted mid-stall
        set_id(32'h400, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(32'h404, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk("rs_stall", 160'(hazard_stall), 160'(1));
        rst_n = 1'b0;
        tick();
        #1 chk("rs_valid", 160'(ID_EX_valid), 160'(0));
        chk("rs_stall_off", 160'(hazard_stall), 160'(0));
        chk("rs_bubble_cnt", 160'(bubble_cnt), 160'(0));
        chk("rs_flush_cnt", 160'(flush_cnt), 160'(0));
        rst_n = 1'b1;
        tick();
        chk("rs_capture", 160'(ID_EX_pc), 160'(32'h404));

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V core. It captures decoded operands and control from the ID stage and presents the registered `ID_EX_*` fields that the EX stage and the forwarding unit consume. It detects load-use and load-branch hazards, stalls PC and IF/ID, and inserts bubbles. It also honours downstream hold and flush requests.

## Interface
- `XLEN`, 32, data/PC width
- `REG_ADDR_WIDTH`, `` `REG_ADDR_WIDTH ``, register index width
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `ID_pc`, `ID_rs1_data`, `ID_rs2_data`, `ID_imm`  in  XLEN  decoded PC, register-file reads, immediate
- `ID_rs1`, `ID_rs2`, `ID_rd`  in  REG_ADDR_WIDTH  register indices
- `ID_uses_rs1`, `ID_uses_rs2`  in  1  instruction actually reads rs1/rs2
- `ID_is_branch`  in  1  ID holds BEQ (compared in ID)
- `ID_valid`  in  1  ID holds a real instruction
- `ID_reg_wr_en`, `ID_mem_rd_en`, `ID_mem_wr_en`, `ID_mem_to_reg`, `ID_alu_src`  in  1  control bits
- `ID_alu_op`  in  4  ALU operation
- `EX_MEM_mem_rd_en`  in  1  EX/MEM holds a load
- `EX_MEM_rd`  in  REG_ADDR_WIDTH  EX/MEM destination
- `ex_hold`  in  1  downstream (memory wait) freeze of ID/EX
- `flush`  in  1  kill ID/EX contents
- `hazard_stall`  out  1  combinational; freeze PC and IF/ID this cycle
- `ID_EX_*`  out  same widths as the `ID_*` inputs  registered copies of every `ID_*` input above except `ID_uses_*` and `ID_is_branch`
- `bubble_cnt`, `flush_cnt`  out  32  performance counters (see Configuration)

## Operation
- Load-use hazard (`lu`) = `ID_valid & ID_EX_valid & ID_EX_mem_rd_en & (ID_EX_rd != 0)` & ((`ID_uses_rs1` & `ID_rs1 == ID_EX_rd`) | (`ID_uses_rs2` & `ID_rs2 == ID_EX_rd`)).
- Load-branch second hazard (`lb`) = `ID_valid & ID_is_branch & EX_MEM_mem_rd_en & (EX_MEM_rd != 0)` & (rs1 or rs2 match `EX_MEM_rd`, gated by `uses_*`). It applies only to branches, because load data is not forwardable from EX/MEM in ID.
- `hazard_stall = (lu | lb) & ~flush`.
- Next-state priority per cycle, first match wins:
  1. `!rst_n`: clear the register.
  2. `flush`: load a bubble.
  3. `ex_hold`: hold all `ID_EX_*` unchanged.
  4. `hazard_stall`: load a bubble.
  5. Otherwise: capture all `ID_*` fields.
- Bubble: every `ID_EX_*` field = 0. This includes data fields, so `valid` = 0, `rd` = 0 and `reg_wr_en` = 0. Downstream forwarding therefore never matches a bubble.
- A load followed by a dependent branch stalls exactly 2 cycles: `lu`, then `lb`. A load followed by a dependent ALU op stalls exactly 1 cycle.
- `hazard_stall` is evaluated independently of `ex_hold`. When both are high, the register holds (rule 3) and the stall remains asserted.
- An invalid ID slot (`ID_valid` = 0) never raises `hazard_stall`.

## Timing
- Reset: all `ID_EX_*` = 0, `bubble_cnt` = `flush_cnt` = 0, `hazard_stall` = 0 while the inputs are quiescent.
- Latency: one cycle from `ID_*` to `ID_EX_*`.
- `hazard_stall` is same-cycle combinational from inputs and current register state; it has no registered path.
- Reset asserted mid-stall: the register clears at that edge. The stall deasserts the cycle after, because `ID_EX_valid` = 0.
- `flush` with `ex_hold`: the flush wins and the instruction is discarded.

## Configuration
- `ID_EX_PERF_CNT_EN` defined:
  - `bubble_cnt` increments on each edge where rule 4 loads a bubble.
  - `flush_cnt` increments on each edge where rule 2 applies.
  - Both saturate at 2^32-1 and clear on reset.
- Not defined: both counter ports are present and tied to 0; no counter flops are synthesised.

## Test plan
- Reset then capture: `rst_n` = 0 for 2 cycles -> all outputs 0. Release, drive `ID_pc` = 0x100, `ID_rd` = 5, `ID_reg_wr_en` = 1, `ID_valid` = 1 -> next cycle `ID_EX_pc` = 0x100, `ID_EX_rd` = 5, `ID_EX_valid` = 1.
- Load-use: `lw x5` in ID/EX; ID holds `add x6,x5,x7` (`uses_rs1` = 1) -> `hazard_stall` = 1 for 1 cycle, bubble in ID/EX, `bubble_cnt` = 1 (macro on). The add is captured on the following edge.
- Load-branch: `lw x5` followed by `beq x5,x0` -> `hazard_stall` high for exactly 2 consecutive cycles, 2 bubbles; the branch is captured on the third edge.
- Zero register: `lw x0` followed by `add x1,x0,x0` -> `hazard_stall` = 0 and no bubble.
- Hold and flush: `ex_hold` = 1 for 3 cycles -> `ID_EX_*` constant. Assert `flush` together with `ex_hold` -> next cycle `ID_EX_valid` = 0 and `flush_cnt` = 1.
- Macro off: repeat the load-use scenario -> `bubble_cnt` = `flush_cnt` = 0 throughout.
